// File: rtl/mul_div_pkg.sv
// Shared op encodings and FSM state type for the iterative multiply/divide unit.
package mul_div_pkg;

    localparam logic [1:0] OP_MULU = 2'b00;
    localparam logic [1:0] OP_MUL  = 2'b01;
    localparam logic [1:0] OP_DIVU = 2'b10;
    localparam logic [1:0] OP_DIV  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mul_div_step.sv
// One iteration of the unsigned datapath: shift-add multiply or restoring shift-subtract divide.
// The divide path exists only when MUL_DIV_UNIT_DIV_EN is defined.
module mul_div_step #(
    parameter int N = 32
) (
`ifdef MUL_DIV_UNIT_DIV_EN
    input  logic         is_div,
`endif
    input  logic [N-1:0] hi,
    input  logic [N-1:0] lo,
    input  logic [N-1:0] operand,
    output logic [N-1:0] next_hi,
    output logic [N-1:0] next_lo
);
    logic [N:0] sum;
`ifdef MUL_DIV_UNIT_DIV_EN
    logic [N:0] shifted;
    logic [N:0] diff;
`endif

    // Multiply: lo holds the multiplier, consumed LSB first; the product shifts in from hi.
    always_comb begin
        sum     = {1'b0, hi} + (lo[0] ? {1'b0, operand} : '0);
        next_hi = sum[N:1];
        next_lo = {sum[0], lo[N-1:1]};
`ifdef MUL_DIV_UNIT_DIV_EN
        shifted = {hi, lo[N-1]};
        diff    = shifted - {1'b0, operand};
        // Divide: hi is the partial remainder, lo the dividend turning into the quotient.
        if (is_div) begin
            if (shifted >= {1'b0, operand}) begin
                next_hi = diff[N-1:0];
                next_lo = {lo[N-2:0], 1'b1};
            end else begin
                next_hi = shifted[N-1:0];
                next_lo = {lo[N-2:0], 1'b0};
            end
        end
`endif
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit: N cycles per operation on operand magnitudes, sign fixed at the end.
// Divide support is compiled in only when MUL_DIV_UNIT_DIV_EN is defined.
module mul_div_unit
    import mul_div_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] hi,
    output logic [N-1:0] lo,
    output logic         div_by_zero,
    output logic         busy,
    output state_t       state
);
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    // Handshakes: a request transfers on an edge with in_valid & in_ready, a result on an
    // edge with out_valid & out_ready; flush overrides both and drops the operation.
    state_t         state_q, state_next;
    logic           accept, last, imm, load_imm, load_fin;
    logic           sign_a, sign_b, neg_q;
    logic [N-1:0]   mag_a, mag_b, imm_hi, imm_lo;
    logic [N-1:0]   acc_hi, acc_lo, operand, step_hi, step_lo, fin_hi, fin_lo;
    logic [2*N-1:0] prod;
    logic [CW-1:0]  cnt;
`ifdef MUL_DIV_UNIT_DIV_EN
    logic           div_q, neg_r;
`endif

    assign state    = state_q;
    assign accept   = in_valid & in_ready & ~flush;
    assign last     = (cnt == LAST);
    assign sign_a   = op[0] & a[N-1];
    assign sign_b   = op[0] & b[N-1];
    assign mag_a    = sign_a ? -a : a;
    assign mag_b    = sign_b ? -b : b;
`ifdef MUL_DIV_UNIT_DIV_EN
    assign imm      = op[1] & (b == '0);
    assign imm_hi   = a;
    assign imm_lo   = '1;
`else
    assign imm      = op[1];
    assign imm_hi   = '0;
    assign imm_lo   = '0;
`endif
    assign load_imm = accept & imm;
    assign load_fin = (state_q == RUN) & last & ~flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_next;
    end

    always_comb begin
        state_next = state_q;
        if (flush) begin
            state_next = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (accept) state_next = imm ? DONE : RUN;
                RUN:     if (last) state_next = DONE;
                DONE:    if (out_ready) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q != IDLE);
    end

    mul_div_step #(.N(N)) u_step (
`ifdef MUL_DIV_UNIT_DIV_EN
        .is_div  (div_q),
`endif
        .hi      (acc_hi),
        .lo      (acc_lo),
        .operand (operand),
        .next_hi (step_hi),
        .next_lo (step_lo)
    );

    // Sign correction applied to the final iteration's output as it is captured.
    always_comb begin
        prod = {step_hi, step_lo};
        if (neg_q) prod = -prod;
        fin_hi = prod[2*N-1:N];
        fin_lo = prod[N-1:0];
`ifdef MUL_DIV_UNIT_DIV_EN
        if (div_q) begin
            fin_lo = neg_q ? -step_lo : step_lo;
            fin_hi = neg_r ? -step_hi : step_hi;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_hi      <= '0;
            acc_lo      <= '0;
            operand     <= '0;
            cnt         <= '0;
            neg_q       <= 1'b0;
`ifdef MUL_DIV_UNIT_DIV_EN
            div_q       <= 1'b0;
            neg_r       <= 1'b0;
`endif
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
        end else begin
            if (accept) begin
                acc_hi  <= '0;
                acc_lo  <= mag_a;
                operand <= mag_b;
                cnt     <= '0;
                neg_q   <= sign_a ^ sign_b;
`ifdef MUL_DIV_UNIT_DIV_EN
                div_q   <= op[1];
                neg_r   <= sign_a;
`endif
            end else if (state_q == RUN) begin
                acc_hi  <= step_hi;
                acc_lo  <= step_lo;
                cnt     <= cnt + CW'(1);
            end
            if (load_imm) begin
                hi          <= imm_hi;
                lo          <= imm_lo;
                div_by_zero <= 1'b1;
            end else if (load_fin) begin
                hi          <= fin_hi;
                lo          <= fin_lo;
                div_by_zero <= 1'b0;
            end
        end
    end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have parameter N, default 32, giving operand width in bits (legal range 4..64).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port flush, input, 1 bit: synchronous abort of any operation in flight.
REQ-005 SHALL have port in_valid, input, 1 bit: a request is present.
REQ-006 SHALL have port in_ready, output, 1 bit: the unit can accept a request.
REQ-007 SHALL have port op, input, 2 bits: 00 MULU, 01 MUL (signed), 10 DIVU, 11 DIV (signed).
REQ-008 SHALL have ports a and b, inputs, N bits each: the operands.
REQ-009 SHALL have port out_valid, output, 1 bit: a result is held.
REQ-010 SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-011 SHALL have ports hi and lo, outputs, N bits each: result halves.
REQ-012 SHALL have port div_by_zero, output, 1 bit: the held result came from a divide with b==0.
REQ-013 SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-014 SHALL implement an FSM with states IDLE, RUN and DONE; in_ready equals (state==IDLE), and out_valid equals (state==DONE).
REQ-015 SHALL accept a request on an edge where in_valid&in_ready is high, latching op, |a| and |b| (magnitudes for signed ops) plus the result signs, then entering RUN.
REQ-016 SHALL, in RUN, perform one shift-add (multiply) or one restoring shift-subtract (divide) iteration per cycle for exactly N cycles, then enter DONE.
REQ-017 SHALL apply sign correction on the RUN->DONE edge, so out_valid rises N cycles after the accepting edge.
REQ-018 SHALL produce, for multiply ops, {hi,lo} equal to the full 2N-bit product (two's complement for MUL).
REQ-019 SHALL produce, for divide ops, lo = quotient and hi = remainder, with the quotient truncated toward zero and the remainder taking the sign of the dividend.
REQ-020 SHALL handle DIV of the most-negative value by -1 as lo = most-negative value, hi = 0, with no flag raised.
REQ-021 SHALL, for a divide with b==0, skip RUN and enter DONE on the accepting edge with lo = all ones, hi = a, div_by_zero = 1.
REQ-022 SHALL hold hi, lo and div_by_zero stable in DONE until out_valid&out_ready, then return to IDLE; there is no same-cycle re-accept.
REQ-023 SHALL, on flush, enter IDLE on the next edge from any state and discard the result; flush has priority over both accept and out_ready.
REQ-024 SHALL leave hi, lo and div_by_zero unchanged outside DONE; they are meaningful only while out_valid is high.

Reset
REQ-025 SHALL, on reset asserted, immediately force state IDLE; hi, lo, div_by_zero, busy and out_valid all 0; in_ready 1.
REQ-026 SHALL, on reset asserted mid-RUN or in DONE, abandon the operation with no result ever presented.

Configuration
REQ-027 SHALL gate divide support with the macro MUL_DIV_UNIT_DIV_EN.
REQ-028 SHALL, when MUL_DIV_UNIT_DIV_EN is defined, support all four ops as specified above.
REQ-029 SHALL, when MUL_DIV_UNIT_DIV_EN is undefined, contain no divide hardware; ops 10/11 then enter DONE on the accepting edge with hi = lo = 0 and div_by_zero = 1.

Structure
REQ-030 SHALL place op encodings (OP_MULU, OP_MUL, OP_DIVU, OP_DIV) and the FSM state enum in shared package mul_div_pkg.
REQ-031 SHALL isolate the per-iteration add/subtract-and-shift datapath in sub-module mul_div_step, parameterised by N; mul_div_unit holds the FSM, the iteration counter and sign handling.

Verification (bench uses N=8)
REQ-032 SHALL cover: MULU a=200, b=3 -> after 8 cycles hi=0x02, lo=0x58, div_by_zero=0.
REQ-033 SHALL cover: MUL a=0xFD (-3), b=5 -> hi=0xFF, lo=0xF1.
REQ-034 SHALL cover: DIVU a=100, b=7 -> lo=0x0E, hi=0x02; then DIV a=0xF9 (-7), b=2 -> lo=0xFD, hi=0xFF.
REQ-035 SHALL cover: DIVU a=0x2A, b=0 -> out_valid on the edge after accept with lo=0xFF, hi=0x2A, div_by_zero=1.
REQ-036 SHALL cover: out_ready held low for 5 cycles in DONE -> outputs stable and in_ready low; out_ready high -> IDLE next edge.
REQ-037 SHALL cover: flush at RUN cycle 3 and, separately, reset at RUN cycle 3 -> IDLE with no out_valid pulse; a following MULU 2*3 -> lo=0x06, hi=0x00.
